// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IDLE/RUN/HALT control FSM and IF/ID pipeline register.
// Optional macro FETCH_WRAP_EN limits the PC to a 64-word instruction space.
module instr_fetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic [15:0] instr_in,
    output logic [15:0] pc_addr,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic        ifid_valid,
    output logic [1:0]  fetch_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] ifpc_q, ifpc_d;
    logic        valid_q, valid_d;

    logic [15:0] pc_inc;
    logic [15:0] redirect_pc;

`ifdef FETCH_WRAP_EN
    // 64-entry instruction memory: upper PC bits are always zero.
    assign pc_inc      = {10'b0, pc_q[5:0] + 6'd1};
    assign redirect_pc = {10'b0, branch_target[5:0]};
`else
    assign pc_inc      = pc_q + 16'd1;
    assign redirect_pc = branch_target;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                pc_d    = 16'h0000;
                valid_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Priority: halt over branch flush over stall hold.
                if (halt) begin
                    state_d = ST_HALT;
                    valid_d = 1'b0;
                end else if (branch_taken) begin
                    pc_d    = redirect_pc;
                    instr_d = 16'h0000;
                    ifpc_d  = 16'h0000;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    pc_d    = pc_inc;
                    instr_d = instr_in;
                    ifpc_d  = pc_inc;
                    valid_d = 1'b1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
                pc_d    = 16'h0000;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= 16'h0000;
            instr_q <= 16'h0000;
            ifpc_q  <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            valid_q <= valid_d;
        end
    end

    assign pc_addr     = pc_q;
    assign ifid_instr  = instr_q;
    assign ifid_pc     = ifpc_q;
    assign ifid_valid  = valid_q;
    assign fetch_state = state_q;

endmodule
